// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped, write-through, read-allocate data cache.
// Hits answer with zero latency; misses fill a whole line from external memory.
// Ports: clock/reset (sync, active-high); en/we/addr/wd request in;
//   stall/rd response out; ext_req/ext_we/ext_addr/ext_wd registered
//   external request; ext_ack/ext_rd external completion.
// Optional macro DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dmem_cache #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        stall,
  output logic [31:0] rd,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wd,
  input  logic        ext_ack,
  input  logic [31:0] ext_rd
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = LINES << OFFSET_BITS;
  localparam int AW       = INDEX_BITS + OFFSET_BITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] WDONE = 2'd3;

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;

  assign offset = addr[OFFSET_BITS-1:0];
  assign index  = addr[OFFSET_BITS +: INDEX_BITS];
  assign tag    = addr[31 -: TAG_BITS];

  logic [31:0]         data_q [WORDS];
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [LINES-1:0]    valid_q, valid_d;

  logic [1:0]             state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic                   ext_req_q, ext_req_d;
  logic                   ext_we_q, ext_we_d;
  logic [31:0]            ext_addr_q, ext_addr_d;
  logic [31:0]            ext_wd_q, ext_wd_d;

  logic          data_we;
  logic [AW-1:0] data_waddr;
  logic [31:0]   data_wdata;
  logic          tag_we;
  logic          hit;
  logic          ack;

  assign hit     = valid_q[index] && (tag_q[index] == tag);
  assign ack     = ext_ack && ext_req_q;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    ext_req_d  = ext_req_q;
    ext_we_d   = ext_we_q;
    ext_addr_d = ext_addr_q;
    ext_wd_d   = ext_wd_q;
    data_we    = 1'b0;
    data_waddr = {index, offset};
    data_wdata = wd;
    tag_we     = 1'b0;
    stall      = 1'b0;
    rd         = '0;
    case (state_q)
      IDLE: begin
        if (en && we) begin
          stall      = 1'b1;
          state_d    = WRITE;
          ext_req_d  = 1'b1;
          ext_we_d   = 1'b1;
          ext_addr_d = addr;
          ext_wd_d   = wd;
        end else if (en && hit) begin
          rd = data_q[{index, offset}];
        end else if (en) begin
          // Drop valid now so a half-filled line can never hit.
          stall          = 1'b1;
          state_d        = FILL;
          cnt_d          = '0;
          valid_d[index] = 1'b0;
          ext_req_d      = 1'b1;
          ext_we_d       = 1'b0;
          ext_addr_d     = {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        end
      end
      FILL: begin
        stall = 1'b1;
        if (ack) begin
          data_we    = 1'b1;
          data_waddr = {index, cnt_q};
          data_wdata = ext_rd;
          if (cnt_q == {OFFSET_BITS{1'b1}}) begin
            tag_we         = 1'b1;
            valid_d[index] = 1'b1;
            state_d        = IDLE;
            cnt_d          = '0;
            ext_req_d      = 1'b0;
          end else begin
            cnt_d      = cnt_inc;
            ext_addr_d = {addr[31:OFFSET_BITS], cnt_inc};
          end
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (ack) begin
          // Write-through without allocate: only refresh a resident line.
          data_we   = hit;
          state_d   = WDONE;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      ext_req_q  <= 1'b0;
      ext_we_q   <= 1'b0;
      ext_addr_q <= '0;
      ext_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      ext_req_q  <= ext_req_d;
      ext_we_q   <= ext_we_d;
      ext_addr_q <= ext_addr_d;
      ext_wd_q   <= ext_wd_d;
    end
  end

  // Arrays are not cleared by reset; only the valid bits are.
  always_ff @(posedge clock) begin
    if (!reset && data_we) data_q[data_waddr] <= data_wdata;
    if (!reset && tag_we) tag_q[index] <= tag;
  end

  assign ext_req  = ext_req_q;
  assign ext_we   = ext_we_q;
  assign ext_addr = ext_addr_q;
  assign ext_wd   = ext_wd_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        fill_done_q, fill_done_d;

  // The load replayed right after a fill hits, but is not a first-time hit.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    fill_done_d  = (state_q == FILL) && (state_d == IDLE);
    if (state_q == IDLE && en && !we) begin
      if (hit && !fill_done_q) hit_count_d = hit_count_q + 32'd1;
      if (!hit) miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      fill_done_q  <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      fill_done_q  <= fill_done_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dmem_cache.sv
// tb_dmem_cache: randomized scoreboard bench for dmem_cache.
// Drives directed and random loads/stores against a reference model.
module tb_dmem_cache;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        stall;
  logic [31:0] rd;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wd;
  logic        ext_ack = 1'b0;
  logic [31:0] ext_rd = '0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dmem_cache dut (
    .clock(clock),
    .reset(reset),
    .en(en),
    .we(we),
    .addr(addr),
    .wd(wd),
    .stall(stall),
    .rd(rd),
    .ext_req(ext_req),
    .ext_we(ext_we),
    .ext_addr(ext_addr),
    .ext_wd(ext_wd),
    .ext_ack(ext_ack),
    .ext_rd(ext_rd)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        hit;
    logic [31:0] rd;
    logic [7:0]  n_ext;
    logic        xwe;
    logic [31:0] xaddr;
    logic [31:0] xwd;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } xact_t;

  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  xact_t ext_log[$];

  logic [31:0] ext_mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  bit          mvalid [64];
  logic [31:0] mtag [64];

  int    stall_cyc = 0;
  int    dly = 0;
  int    wt = 0;
  bit    pend = 0;
  xact_t pend_x;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return a * 32'd3;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic consume();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_consume: got addr %h expected none", addr);
    end else begin
      e = exp_q.pop_front();
      chk("rd", rd, e.rd);
      checks++;
      if ((stall_cyc == 0) != e.hit) begin
        errors++;
        $display("FAIL hit_latency: got stall cycles %0d expected hit=%0d",
                 stall_cyc, e.hit);
      end
      chk("ext_count", ext_log.size(), {24'd0, e.n_ext});
      for (int i = 0; i < int'(e.n_ext) && i < ext_log.size(); i++) begin
        chk("ext_we", {31'd0, ext_log[i].we}, {31'd0, e.xwe});
        chk("ext_addr", ext_log[i].addr, e.xaddr + (e.xwe ? 0 : i));
        if (e.xwe) chk("ext_wd", ext_log[i].wd, e.xwd);
      end
    end
    ext_log.delete();
    stall_cyc = 0;
  endtask

  // Monitor first, then the external memory responder.
  always @(negedge clock) begin
    if (reset) begin
      stall_cyc = 0;
      pend = 0;
      wt = 0;
      ext_ack = 1'b0;
    end else begin
      if (en && stall) stall_cyc++;
      if (en && !stall) consume();
      ext_ack = 1'b0;
      if (ext_req) begin
        if (pend) begin
          checks++;
          if (ext_we !== pend_x.we || ext_addr !== pend_x.addr ||
              ext_wd !== pend_x.wd) begin
            errors++;
            $display("FAIL ext_stable: got %h expected %h",
                     ext_addr, pend_x.addr);
          end
        end
        pend = 1;
        pend_x = '{we: ext_we, addr: ext_addr, wd: ext_wd};
        if (wt >= dly) begin
          ext_ack = 1'b1;
          if (ext_we) ext_mem[ext_addr] = ext_wd;
          else ext_rd = ext_mem.exists(ext_addr) ?
                        ext_mem[ext_addr] : init_val(ext_addr);
          ext_log.push_back(pend_x);
          pend = 0;
          wt = 0;
          dly = $urandom_range(0, 2);
        end else begin
          wt++;
        end
      end else begin
        pend = 0;
        if ($urandom_range(0, 7) == 0) begin
          ext_ack = 1'b1;
          ext_rd = $urandom;
        end
      end
    end
  end

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Called at posedge+1; returns at posedge+1 after the access is consumed.
  task automatic issue(bit w, logic [31:0] a, logic [31:0] d);
    exp_t        e;
    int unsigned line;
    logic [31:0] t;
    bit          done;
    line = (a / 4) % 64;
    t = a / 256;
    e = '0;
    if (w) begin
      e.n_ext = 8'd1;
      e.xwe = 1'b1;
      e.xaddr = a;
      e.xwd = d;
      ref_mem[a] = d;
    end else begin
      e.rd = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
      e.xaddr = a - (a % 4);
      if (mvalid[line] && mtag[line] == t) begin
        e.hit = 1'b1;
      end else begin
        e.n_ext = 8'd4;
        mvalid[line] = 1;
        mtag[line] = t;
      end
    end
    exp_q.push_back(e);
    en = 1'b1;
    we = w;
    addr = a;
    wd = d;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clock);
      if (!stall) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got stall for addr %h expected completion", a);
      finish_now();
    end
    @(posedge clock);
    #1;
    en = 1'b0;
  endtask

  task automatic reset_mid_fill(logic [31:0] a);
    bit hit2;
    en = 1'b1;
    we = 1'b0;
    addr = a;
    hit2 = 0;
    for (int c = 0; c < 100 && !hit2; c++) begin
      @(posedge clock);
      if (ext_log.size() >= 2) hit2 = 1;
    end
    if (!hit2) begin
      checks++;
      errors++;
      $display("FAIL fill_timeout: got %0d acks expected 2", ext_log.size());
      finish_now();
    end
    #1;
    reset = 1'b1;
    en = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_ext_req", {31'd0, ext_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    reset = 1'b0;
    ext_log.delete();
    stall_cyc = 0;
    for (int i = 0; i < 64; i++) mvalid[i] = 0;
  endtask

  initial begin
    logic [31:0] a;
    bit          w;
    for (int i = 0; i < 64; i++) mvalid[i] = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_ext_req", {31'd0, ext_req}, 32'd0);
    chk("reset_ext_we", {31'd0, ext_we}, 32'd0);
    chk("reset_ext_addr", ext_addr, 32'd0);
    chk("reset_ext_wd", ext_wd, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_rd", rd, 32'd0);
    reset = 1'b0;

    issue(0, 32'h10, 0);
    issue(0, 32'h12, 0);
    issue(1, 32'h12, 32'hDEAD);
    issue(0, 32'h12, 0);
    issue(1, 32'h200, 32'h1234);
    issue(0, 32'h200, 0);
    issue(0, 32'h110, 0);
    issue(0, 32'h10, 0);
    issue(0, 32'h110, 0);
    reset_mid_fill(32'h10);
    @(posedge clock);
    #1;
    issue(0, 32'h10, 0);
    issue(0, 32'h13, 0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) |
               $urandom_range(0, 3);
      w = ($urandom_range(0, 3) == 0);
      issue(w, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
    end

    repeat (3) @(posedge clock);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    finish_now();
  end

endmodule

// File: doc/dmem_cache.md
Name: dmem_cache

Overview:
- Direct-mapped, write-through, read-allocate data cache on the slave side of the DataMemory handshake.
- Sits directly downstream of the execute/memory stage. It answers hits with zero-clock latency and no stall. It raises stall while it talks to the external memory port.
- Addresses are word addresses; one word is 32 bits.

Parameters:
- INDEX_BITS, 6, log2 of the number of lines (64 lines).
- OFFSET_BITS, 2, log2 of the words per line (4 words).
- Tag width is 32-INDEX_BITS-OFFSET_BITS and is derived, not a parameter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- en  in  1  access request (DataMemory.slave en).
- we  in  1  1 = store, 0 = load.
- addr  in  32  word address.
- wd  in  32  store data.
- stall  out  1  combinational; request not complete this cycle.
- rd  out  32  combinational load data.
- ext_req  out  1  registered external request.
- ext_we  out  1  registered external write enable.
- ext_addr  out  32  registered external word address.
- ext_wd  out  32  registered external write data.
- ext_ack  in  1  single-cycle completion pulse from external memory.
- ext_rd  in  32  external read data, valid with ext_ack.

Behaviour:
- Address split: offset = addr[OFFSET_BITS-1:0]; index = next INDEX_BITS bits; tag = remaining upper bits.
- Storage: data array is asynchronous-read distributed RAM; tag and valid bits are per line.
- hit = valid[index] and tag match, evaluated combinationally on the current addr.
- Request rules: the upstream stage holds en/we/addr/wd stable while stall=1. A request is consumed in the cycle en=1 and stall=0.
- FSM states: IDLE, FILL, WRITE, WDONE.
- IDLE, en=0: stall=0, rd=0, no action.
- IDLE, load hit: stall=0; rd = data[index][offset].
- IDLE, load miss: stall=1; next state FILL, word counter = 0.
- IDLE, store: stall=1 regardless of hit; next state WRITE.
- Loads: rd = 0 in every cycle that is not an IDLE load hit.
- FILL:
  - stall=1.
  - Issue reads to line base + counter, counting 0 to 2^OFFSET_BITS-1 in ascending order, line-aligned start.
  - Each ext_ack writes ext_rd into data[index][counter], then the counter increments.
  - On the last ack: set tag, set valid, go to IDLE. The held load then hits the following cycle with stall=0.
  - Valid for the line is cleared on entering FILL, so a partially filled line never hits.
- WRITE:
  - stall=1.
  - ext_req=1, ext_we=1, ext_addr=addr, ext_wd=wd.
  - On ext_ack: if the line hits (tag/valid sampled at that cycle), update data[index][offset]=wd. A store miss does not allocate. Go to WDONE.
- WDONE: stall=0 for exactly one cycle so the store is consumed; go to IDLE.
- External handshake:
  - ext_req and the fields are registered.
  - They are stable from assertion until the cycle ext_ack is seen.
  - After an ack, the next cycle carries either the next fill word or ext_req=0.
  - ext_ack while ext_req=0 is ignored.
  - There is at most one outstanding external transaction.
- Reset values: state IDLE, all valid bits 0, ext_req=0, ext_we=0, ext_addr=0, ext_wd=0, counter 0. stall and rd follow from IDLE with the current inputs.
- Reset mid-operation: FILL or WRITE is abandoned, and no cache entry is updated by that transaction. An ext_ack arriving after reset is ignored. Tag and data arrays are not cleared.
- Same-index conflict: a fill overwrites the previous tag; there is no write-back (write-through).
- addr changing while stall=1 is a protocol violation; behaviour is undefined.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs hit_count (32) and miss_count (32), both reset to 0.
  - hit_count increments once per consumed load that hit in IDLE on first presentation.
  - miss_count increments once per transition IDLE to FILL.
  - Both counters wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold load addr 0x10; external model acks 1 cycle after req and returns ext_rd = ext_addr*3:
  - exactly 4 external reads at 0x10, 0x11, 0x12, 0x13 in order;
  - stall is high throughout, then low one cycle after the last ack with rd=0x30.
- Then load 0x12: stall=0 in the same cycle, rd=0x36, ext_req stays 0.
- Store 0x12 with wd=0xDEAD:
  - one external write (ext_we=1, addr 0x12, wd 0xDEAD);
  - stall drops in WDONE;
  - a following load of 0x12 gives rd=0xDEAD with no external traffic.
- Store miss to 0x200:
  - one external write is issued;
  - a following load of 0x200 misses and fills 0x200..0x203 (no allocate on write).
- Conflict: load 0x110 (same index as 0x10) fills; a following load of 0x10 misses again and refetches 0x10..0x13.
- Assert reset during FILL after 2 acks:
  - ext_req=0 the next cycle and stall=0 with en=0;
  - a later load of 0x10 misses and issues 4 fresh reads.
